// File: rtl/entrada_pkg.sv
// Shared types and constants for the digit-entry block.
//   estado_t   : entry FSM states (empty / typing / full)
//   TECLA_*    : key codes of the edit keys
//   eh_digito  : true for key codes 0x0..0x9
package entrada_pkg;

  typedef enum logic [1:0] {
    VAZIO     = 2'd0,
    DIGITANDO = 2'd1,
    CHEIO     = 2'd2
  } estado_t;

  localparam logic [3:0] TECLA_CONFIRMA = 4'hA;
  localparam logic [3:0] TECLA_APAGA    = 4'hB;
  localparam logic [3:0] TECLA_LIMPA    = 4'hC;

  function automatic logic eh_digito(input logic [3:0] value);
    return value <= 4'd9;
  endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Registered rising-edge detector.
//   clk, rst : clock, asynchronous active-high reset
//   sinal    : level input
//   borda    : high while sinal is 1 and was 0 on the previous clock
// RESET_VALUE sets the remembered level after reset; 1 makes a level that is
// already high through reset wait for a release before it counts as an edge.
module detector_de_borda #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sinal,
  output logic borda
);

  logic sinal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sinal_q <= RESET_VALUE;
    else     sinal_q <= sinal;
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/entrada_de_digitos.sv
// Keypad digit entry: turns decoded key presses into single events, builds a
// BCD entry buffer, handles confirm/backspace/clear and an inactivity timeout.
//   clk, rst       : clock, asynchronous active-high reset
//   tecla_value    : key code, sampled only on the press edge
//   tecla_valid    : level, high while a key is held
//   digitos        : live buffer, newest digit in [3:0]
//   num_digitos    : digits currently held
//   entrada_valor  : last confirmed entry, held until the next confirm
//   entrada_qtd    : digit count of entrada_valor
//   entrada_pronta : one-cycle pulse, new confirmed entry
//   cheio          : buffer full
//   erro           : one-cycle pulse, rejected event
//   timeout        : one-cycle pulse, partial entry discarded by inactivity
module entrada_de_digitos
  import entrada_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        tecla_value,
  input  logic                              tecla_valid,
  output logic [4*MAX_DIGITS-1:0]           digitos,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   num_digitos,
  output logic [4*MAX_DIGITS-1:0]           entrada_valor,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   entrada_qtd,
  output logic                              entrada_pronta,
  output logic                              cheio,
  output logic                              erro,
  output logic                              timeout
);

  localparam int unsigned BW = 4 * MAX_DIGITS;
  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  estado_t       state_q, state_d;
  logic [BW-1:0] dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] valor_q, valor_d;
  logic [CW-1:0] qtd_q, qtd_d;
  logic          pronta_q, pronta_d;
  logic          erro_q, erro_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          evento;
  logic          expira;
  logic [BW-1:0] dig_push;
  logic [CW-1:0] cnt_inc;

  // Reset value 1: a key held through reset is not an event until released.
  detector_de_borda #(
    .RESET_VALUE (1'b1)
  ) u_borda (
    .clk   (clk),
    .rst   (rst),
    .sinal (tecla_valid),
    .borda (evento)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= VAZIO;
      dig_q     <= '0;
      cnt_q     <= '0;
      valor_q   <= '0;
      qtd_q     <= '0;
      pronta_q  <= 1'b0;
      erro_q    <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      valor_q   <= valor_d;
      qtd_q     <= qtd_d;
      pronta_q  <= pronta_d;
      erro_q    <= erro_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    valor_d   = valor_q;
    qtd_d     = qtd_q;
    pronta_d  = 1'b0;
    erro_d    = 1'b0;
    timeout_d = 1'b0;
    timer_d   = timer_q;

    dig_push      = dig_q << 4;
    dig_push[3:0] = tecla_value;
    cnt_inc       = cnt_q + CW'(1);

    if (evento || state_q == VAZIO) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TW'(1);
    end

    expira = (TIMEOUT_CYCLES != 0) && (state_q != VAZIO) && (timer_q == TMR_LAST);

    unique case (state_q)
      VAZIO, DIGITANDO, CHEIO: begin
        if (evento) begin
          if (eh_digito(tecla_value)) begin
            if (state_q == CHEIO) begin
              erro_d = 1'b1;
            end else begin
              dig_d   = dig_push;
              cnt_d   = cnt_inc;
              state_d = (cnt_inc == CNT_MAX) ? CHEIO : DIGITANDO;
            end
          end else begin
            case (tecla_value)
              TECLA_CONFIRMA: begin
                if (state_q == VAZIO) begin
                  erro_d = 1'b1;
                end else begin
                  valor_d  = dig_q;
                  qtd_d    = cnt_q;
                  pronta_d = 1'b1;
                  dig_d    = '0;
                  cnt_d    = '0;
                  state_d  = VAZIO;
                end
              end
              TECLA_APAGA: begin
                if (state_q != VAZIO) begin
                  dig_d   = dig_q >> 4;
                  cnt_d   = cnt_q - CW'(1);
                  state_d = (cnt_q == CW'(1)) ? VAZIO : DIGITANDO;
                end
              end
              TECLA_LIMPA: begin
                dig_d   = '0;
                cnt_d   = '0;
                state_d = VAZIO;
              end
              default: ;  // 0xD..0xF only restart the timer
            endcase
          end
        end else if (expira) begin
          dig_d     = '0;
          cnt_d     = '0;
          state_d   = VAZIO;
          timeout_d = 1'b1;
        end
      end
      default: begin
        // Unused encoding: recover to a clean empty buffer.
        dig_d   = '0;
        cnt_d   = '0;
        state_d = VAZIO;
        timer_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    digitos        = dig_q;
    num_digitos    = cnt_q;
    entrada_valor  = valor_q;
    entrada_qtd    = qtd_q;
    entrada_pronta = pronta_q;
    erro           = erro_q;
    timeout        = timeout_q;
    cheio          = (state_q == CHEIO);
  end

endmodule

// File: tb/tb_entrada_de_digitos.sv
module tb_entrada_de_digitos;

  localparam int unsigned MAXD = 4;
  localparam int unsigned TOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tecla_value = 4'h0;
  logic        tecla_valid = 1'b0;
  logic [15:0] digitos;
  logic [2:0]  num_digitos;
  logic [15:0] entrada_valor;
  logic [2:0]  entrada_qtd;
  logic        entrada_pronta;
  logic        cheio;
  logic        erro;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int pr_n, er_n, to_n, max_num;

  entrada_de_digitos #(
    .MAX_DIGITS     (MAXD),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tecla_value    (tecla_value),
    .tecla_valid    (tecla_valid),
    .digitos        (digitos),
    .num_digitos    (num_digitos),
    .entrada_valor  (entrada_valor),
    .entrada_qtd    (entrada_qtd),
    .entrada_pronta (entrada_pronta),
    .cheio          (cheio),
    .erro           (erro),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n clocks while counting pulses and the largest digit count seen.
  task automatic tick_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      pr_n += int'(entrada_pronta);
      er_n += int'(erro);
      to_n += int'(timeout);
      if (int'(num_digitos) > max_num) max_num = int'(num_digitos);
    end
  endtask

  task automatic clr_counts();
    pr_n = 0; er_n = 0; to_n = 0; max_num = 0;
  endtask

  // Key goes down; returns just after the event edge.
  task automatic down(input logic [3:0] v);
    tecla_value = v;
    tecla_valid = 1'b1;
    tick(1);
  endtask

  task automatic press(input logic [3:0] v, input int hold, input int rel);
    down(v);
    tick(hold - 1);
    tecla_valid = 1'b0;
    tick(rel);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dig"},   32'(digitos), 32'h0);
    chk({tag, "_num"},   32'(num_digitos), 32'h0);
    chk({tag, "_valor"}, 32'(entrada_valor), 32'h0);
    chk({tag, "_qtd"},   32'(entrada_qtd), 32'h0);
    chk({tag, "_flags"}, {28'h0, entrada_pronta, cheio, erro, timeout}, 32'h0);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk_zero("rst");
    rst = 1'b0;
    tick(2);

    // 1, 2, 3 then confirm
    press(4'h1, 20, 10);
    press(4'h2, 20, 10);
    press(4'h3, 20, 10);
    chk("seq_dig", 32'(digitos), 32'h0123);
    chk("seq_num", 32'(num_digitos), 32'd3);
    clr_counts();
    down(4'hA);
    chk("conf_pronta", 32'(entrada_pronta), 32'd1);
    chk("conf_valor", 32'(entrada_valor), 32'h0123);
    chk("conf_qtd", 32'(entrada_qtd), 32'd3);
    chk("conf_dig", 32'(digitos), 32'h0);
    chk("conf_num", 32'(num_digitos), 32'd0);
    tick_count(19);
    tecla_valid = 1'b0;
    tick_count(10);
    chk("conf_single_pulse", 32'(pr_n), 32'd0);

    // Long hold of 5: one digit only; timeout clears it after TOUT clocks
    clr_counts();
    down(4'h5);
    tick_count(39);
    chk("hold_num", 32'(num_digitos), 32'd1);
    chk("hold_dig", 32'(digitos), 32'h0005);
    tick_count(160);
    chk("hold_max_num", 32'(max_num), 32'd1);
    chk("hold_erro", 32'(er_n), 32'd0);
    chk("hold_timeout", 32'(to_n), 32'd1);
    chk("hold_dig_end", 32'(digitos), 32'h0);
    tecla_valid = 1'b0;
    tick(5);

    // Fill, overflow, backspace
    press(4'h9, 5, 5);
    press(4'h8, 5, 5);
    press(4'h7, 5, 5);
    press(4'h6, 5, 5);
    chk("full_cheio", 32'(cheio), 32'd1);
    chk("full_dig", 32'(digitos), 32'h9876);
    chk("full_num", 32'(num_digitos), 32'd4);
    down(4'h4);
    chk("ovf_erro", 32'(erro), 32'd1);
    chk("ovf_dig", 32'(digitos), 32'h9876);
    tick(1);
    chk("ovf_erro_end", 32'(erro), 32'd0);
    tecla_valid = 1'b0;
    tick(4);
    press(4'hB, 5, 5);
    chk("bs_dig", 32'(digitos), 32'h0987);
    chk("bs_num", 32'(num_digitos), 32'd3);
    chk("bs_cheio", 32'(cheio), 32'd0);
    press(4'hC, 5, 5);
    chk("clr_num", 32'(num_digitos), 32'd0);

    // Confirm on empty, then 4 and clear
    down(4'hA);
    chk("empty_conf_erro", 32'(erro), 32'd1);
    chk("empty_conf_pronta", 32'(entrada_pronta), 32'd0);
    chk("empty_conf_valor", 32'(entrada_valor), 32'h0123);
    tick(4);
    tecla_valid = 1'b0;
    tick(5);
    press(4'h4, 5, 5);
    chk("four_dig", 32'(digitos), 32'h0004);
    down(4'hC);
    chk("lim_dig", 32'(digitos), 32'h0);
    chk("lim_pulses", {29'h0, entrada_pronta, erro, timeout}, 32'h0);
    tick(4);
    tecla_valid = 1'b0;
    tick(5);

    // Timeout exactly TOUT clocks after the event edge
    down(4'h7);
    tecla_valid = 1'b0;
    tick(TOUT - 1);
    chk("to_before", {31'h0, timeout}, 32'd0);
    chk("to_before_dig", 32'(digitos), 32'h0007);
    tick(1);
    chk("to_pulse", {31'h0, timeout}, 32'd1);
    chk("to_dig", 32'(digitos), 32'h0);
    tick(1);
    chk("to_pulse_end", {31'h0, timeout}, 32'd0);

    // Event on the expiry cycle wins and restarts the timer
    down(4'h7);
    tecla_valid = 1'b0;
    tick(TOUT - 1);
    down(4'h8);
    tecla_valid = 1'b0;
    chk("race_dig", 32'(digitos), 32'h0078);
    chk("race_to", {31'h0, timeout}, 32'd0);
    tick(TOUT - 1);
    chk("race_keep", 32'(digitos), 32'h0078);
    tick(1);
    chk("race_to2", {31'h0, timeout}, 32'd1);
    tick(2);

    // Key held across reset deassertion
    tecla_value = 4'h3;
    tecla_valid = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("held_rst_num", 32'(num_digitos), 32'd0);
    tecla_valid = 1'b0;
    tick(2);
    press(4'h3, 3, 3);
    chk("repress_dig", 32'(digitos), 32'h0003);
    press(4'hA, 3, 3);
    press(4'h5, 3, 3);
    chk("pre_rst_valor", 32'(entrada_valor), 32'h0003);

    // Mid-entry reset
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick(2);
    rst = 1'b0;
    clr_counts();
    tick_count(5);
    chk_zero("post_rst");
    chk("post_rst_pulses", 32'(pr_n + er_n + to_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/entrada_de_digitos.md
Name: entrada_de_digitos

Overview:
- Downstream consumer of the keypad decoder's tecla_value/tecla_valid pair.
- Turns each key press into exactly one event and accumulates decimal digits into a BCD entry buffer.
- Handles the edit keys (confirm, backspace, clear) and discards an abandoned entry after an inactivity timeout.
- Delivers a confirmed entry to later stages (lock/password compare) as a latched value plus a one-cycle pulse.

Parameters:
- MAX_DIGITS, 4: capacity of the entry buffer in BCD digits (legal range 1..8).
- TIMEOUT_CYCLES, 1000: idle clocks after the last key event before a partial entry is discarded; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- tecla_value  in  4  key code from the decoder; meaningful only while tecla_valid=1.
- tecla_valid  in  1  level, high for as long as a decoded key is held.
- digitos  out  4*MAX_DIGITS  live buffer; the newest digit is in [3:0]; unused nibbles are 0.
- num_digitos  out  $clog2(MAX_DIGITS+1)  number of digits currently held.
- entrada_valor  out  4*MAX_DIGITS  last confirmed entry, held until the next confirm.
- entrada_qtd  out  $clog2(MAX_DIGITS+1)  digit count of entrada_valor.
- entrada_pronta  out  1  one-cycle pulse: a new entrada_valor is available.
- cheio  out  1  buffer holds MAX_DIGITS digits.
- erro  out  1  one-cycle pulse: rejected event (digit while full, confirm while empty).
- timeout  out  1  one-cycle pulse: partial entry discarded by inactivity.

Behaviour:
- Reset (async): all outputs 0; FSM state VAZIO; timer 0; valid_d=1.
  - valid_d=1 means a key held through reset is ignored until it is released.
- Event detection: evento = tecla_valid & ~valid_d. valid_d <= tecla_valid every clock.
  - A key held N cycles produces exactly one event.
  - tecla_value is sampled on the event cycle only.
- Key classes:
  - 0x0–0x9: digit.
  - 0xA: confirm.
  - 0xB: backspace.
  - 0xC: clear.
  - 0xD, 0xE, 0xF: ignored; no pulse, but the timer still restarts.
- All outputs are registered. The effect of an event at edge k is visible after edge k.
- Pulses are high for exactly the one cycle after their triggering edge.
- FSM states: VAZIO (count=0), DIGITANDO (0<count<MAX), CHEIO (count=MAX).
  - Digit in VAZIO/DIGITANDO: digitos <= {digitos[4*MAX-5:0], value}; count+1; go to DIGITANDO, or CHEIO when count reaches MAX.
  - Digit in CHEIO: buffer unchanged; erro pulse.
  - Backspace with count>0: digitos <= digitos>>4; count-1; state follows count. Backspace in VAZIO: no-op, no erro.
  - Clear: digitos=0, count=0, go to VAZIO; no pulse.
  - Confirm with count>0:
    - entrada_valor <= digitos; entrada_qtd <= count; entrada_pronta pulse.
    - Buffer cleared; go to VAZIO.
  - Confirm in VAZIO: erro pulse; entrada_valor unchanged.
- cheio = (state==CHEIO).
- Timer:
  - Cleared on every event and whenever the state is VAZIO.
  - Otherwise increments by 1 per clock, saturating.
  - When timer == TIMEOUT_CYCLES-1 with no event that cycle: buffer cleared, go to VAZIO, timeout pulse.
  - So the timeout fires TIMEOUT_CYCLES clocks after the last event.
- Simultaneous event and timeout expiry: the event wins and the timer restarts.
- Reset mid-entry: buffer and latched entry are lost; no pulse is emitted.
- Invalid/unused state encodings recover to VAZIO with the buffer cleared.

Decomposition:
- Package entrada_pkg:
  - enum estado_t {VAZIO, DIGITANDO, CHEIO}.
  - Key-code constants TECLA_CONFIRMA=4'hA, TECLA_APAGA=4'hB, TECLA_LIMPA=4'hC.
  - Function eh_digito(value) returning value<=9.
- One sub-module, detector_de_borda: registered rising-edge detector with a reset-value parameter, used for evento.
- Timer and buffer stay inline.

Test Plan (MAX_DIGITS=4, TIMEOUT_CYCLES=50):
- Press 1, 2, 3 (each held 20 cycles, released 10), then A -> digitos 0x0123 before A; after A, entrada_valor=0x0123, entrada_qtd=3, single entrada_pronta pulse, digitos=0, num_digitos=0.
- Press 5 once, held 200 cycles -> num_digitos=1 only, digitos=0x0005, no erro.
- Press 9, 8, 7, 6, then 4 -> after four digits cheio=1 and digitos=0x9876; the fifth digit gives an erro pulse and the buffer stays 0x9876. Then B -> 0x0987, num_digitos=3, cheio=0.
- A on an empty buffer -> erro pulse, entrada_pronta stays 0, entrada_valor unchanged. Then 4, C -> digitos=0, no pulse.
- Press 7, then idle with no event for 50 cycles -> timeout pulse exactly 50 clocks after the event edge, digitos=0. A key event at cycle 49 instead keeps the entry and restarts the timer.
- Hold key 3 across reset deassertion, and separately assert rst mid-entry -> held key produces no digit until released and re-pressed; mid-entry reset gives all outputs 0 and no pulses.
